irq_ctrl: RTL and testbench
===========================

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter VEC_BASE, default 16'h0020, meaning the vector address of source 0.
REQ-002 SHALL have parameter N_DEPTH, default 3, meaning the maximum nesting depth; it matches the CPU's 2-bit IRQ depth saturation.
REQ-003 i_clk  input  1  single clock; all state on rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_irq_req  input  8  raw interrupt requests; bit 0 is highest priority.
REQ-006 i_int_en  input  1  CPU global interrupt enable.
REQ-007 i_insn_ce  input  1  CPU instruction-boundary strobe; a take is permitted only when this is 1.
REQ-008 i_iret  input  1  CPU iret-detected pulse.
REQ-009 i_cfg_we  input  1  config register write strobe.
REQ-010 i_cfg_addr  input  2  config register select: 0 MASK, 1 PEND, 2 EDGE, 3 STATUS.
REQ-011 i_cfg_wdata  input  16  config write data; bits [7:0] used.
REQ-012 o_cfg_rdata  output  16  combinational read of the selected register, zero-extended.
REQ-013 o_irq_take  output  1  one-cycle take pulse to the CPU.
REQ-014 o_irq_vector  output  16  registered vector; valid while o_irq_take=1 and held afterwards.
REQ-015 o_depth  output  2  current nesting depth.

Function
REQ-016 Source sync: i_irq_req SHALL pass through a 2-flop synchronizer (s2); edge detect SHALL compare s2 against the previous sample (s3).
REQ-017 EDGE[i]=1: PEND[i] SHALL set on a 0->1 transition of s2[i].
REQ-018 EDGE[i]=1: PEND[i] SHALL clear on a take of source i or on a write of 1 to PEND bit i.
REQ-019 On simultaneous set and clear of an edge PEND bit, set SHALL win.
REQ-020 EDGE[i]=0: PEND[i] SHALL equal s2[i], is not latched, and SHALL ignore writes.
REQ-021 cand = PEND & MASK; the winner SHALL be the lowest set index of cand.
REQ-022 Active stack: SHALL hold N_DEPTH entries of 3-bit id; top = the most recently taken id; o_depth = entry count.
REQ-023 A winner SHALL be eligible iff depth==0, or (depth<N_DEPTH and winner id < top id), i.e. strictly higher priority; equal or lower priority never preempts.
REQ-024 FSM states: IDLE, TAKE, SETTLE.
REQ-025 IDLE->TAKE SHALL occur when an eligible winner exists, i_int_en=1, i_insn_ce=1 and i_iret=0.
REQ-026 On the IDLE->TAKE edge the block SHALL register o_irq_vector = VEC_BASE + {winner,2'b00}, push the winner, and clear its edge PEND bit.
REQ-027 TAKE: o_irq_take SHALL be 1 for exactly this one cycle; next state SETTLE.
REQ-028 SETTLE: a 2-cycle counter SHALL block further takes, then the FSM returns to IDLE.
REQ-029 i_iret with depth>0 SHALL pop the top in any state; with depth==0 it SHALL be ignored (no underflow).
REQ-030 i_iret and a take condition in the same cycle: iret SHALL be processed and the take deferred; arbitration re-evaluates in the next cycle against the popped stack.
REQ-031 Full stack (depth==N_DEPTH): no take; PEND bits are retained.
REQ-032 Level source still asserted after its iret SHALL be re-taken, subject to REQ-023/025.
REQ-033 Config writes: MASK and EDGE SHALL load from wdata[7:0]; PEND is write-1-to-clear; STATUS is read-only = {8'b0, depth[1:0], top_id[2:0], valid, state[1:0]}.
REQ-034 Changing EDGE[i] SHALL clear the latched PEND[i].
REQ-035 A MASK change SHALL affect arbitration from the next cycle; it SHALL NOT abort a TAKE already in progress.

Reset
REQ-036 Asserting i_rst_n=0 SHALL immediately, without a clock, set the FSM to IDLE, MASK=0, EDGE=0, PEND=0, the stack to empty, o_depth=0, o_irq_take=0, o_irq_vector=VEC_BASE, synchronizers=0 and the SETTLE counter=0.
REQ-037 Reset mid-TAKE SHALL drop o_irq_take in the same cycle; after release the block SHALL behave as post-reset with no spurious take.
REQ-038 Release is synchronous to i_clk; the first take is possible no earlier than 3 cycles after release, due to the synchronizer.

Verification
REQ-039 MASK=8'h10, EDGE=8'h10, pulse req[4], int_en=1, insn_ce=1 -> one take pulse, vector 16'h0030, depth 1, PEND[4]=0.
REQ-040 Source 5 active (depth 1); raise level req[2] and req[6] with MASK=8'hFF -> take of source 2, vector 16'h0028, depth 2; source 6 is not taken until two irets.
REQ-041 Depth 3 with ids 6,4,1; raise req[0] -> no take, PEND[0] held; after one iret -> take of source 0, vector 16'h0020.
REQ-042 Take-eligible and i_iret in the same cycle at depth 1 -> no pulse that cycle, depth 0; pulse next cycle.
REQ-043 Assert i_rst_n=0 during TAKE -> o_irq_take=0 in the same cycle, depth 0, o_irq_vector=16'h0020.
REQ-044 Edge-source set and PEND W1C in the same cycle -> PEND remains 1; int_en=0 -> no take until int_en=1.

Source files
------------

// File: rtl/irq_ctrl_if.sv
// rtl/irq_ctrl_if.sv - CPU-side and config-side signal bundle of the interrupt controller
interface irq_ctrl_if;
    logic [7:0]  i_irq_req;
    logic        i_int_en;
    logic        i_insn_ce;
    logic        i_iret;
    logic        i_cfg_we;
    logic [1:0]  i_cfg_addr;
    logic [15:0] i_cfg_wdata;
    logic [15:0] o_cfg_rdata;
    logic        o_irq_take;
    logic [15:0] o_irq_vector;
    logic [1:0]  o_depth;

    modport master (
        output i_irq_req, i_int_en, i_insn_ce, i_iret, i_cfg_we, i_cfg_addr, i_cfg_wdata,
        input  o_cfg_rdata, o_irq_take, o_irq_vector, o_depth
    );

    modport slave (
        input  i_irq_req, i_int_en, i_insn_ce, i_iret, i_cfg_we, i_cfg_addr, i_cfg_wdata,
        output o_cfg_rdata, o_irq_take, o_irq_vector, o_depth
    );
endinterface

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - 8-source priority interrupt controller with nesting stack
module irq_ctrl #(
    parameter logic [15:0] VEC_BASE = 16'h0020,
    parameter int          N_DEPTH  = 3
) (
    input  logic     i_clk,
    input  logic     i_rst_n,
    irq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, TAKE = 2'd1, SETTLE = 2'd2} state_t;
    localparam logic [1:0] DEPTH_MAX = 2'(N_DEPTH);

    state_t      state, state_n;
    logic [7:0]  sync1, sync2, sync3;
    logic [7:0]  mask_r, edge_en, pend_lat;
    logic [2:0]  stk [N_DEPTH];
    logic [1:0]  depth;
    logic        settle_cnt;
    logic [15:0] vec_r;

    logic [7:0]  pend, cand, rise, clr, edge_chg;
    logic [2:0]  win, top_id;
    logic        have_win, eligible, take_go, iret_pop;
    logic        mask_we, pend_we, edge_we;

    assign mask_we  = bus.i_cfg_we && (bus.i_cfg_addr == 2'd0);
    assign pend_we  = bus.i_cfg_we && (bus.i_cfg_addr == 2'd1);
    assign edge_we  = bus.i_cfg_we && (bus.i_cfg_addr == 2'd2);

    // Edge sources read the latched bit, level sources follow the synchronizer
    assign pend     = (edge_en & pend_lat) | (~edge_en & sync2);
    assign cand     = pend & mask_r;
    assign rise     = edge_en & sync2 & ~sync3;
    assign edge_chg = edge_we ? (bus.i_cfg_wdata[7:0] ^ edge_en) : 8'd0;

    always_comb begin
        win      = 3'd0;
        have_win = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (cand[i]) begin
                win      = 3'(i);
                have_win = 1'b1;
            end
        end
    end

    assign top_id   = (depth == 2'd0) ? 3'd0 : stk[depth - 2'd1];
    assign eligible = have_win &&
                      ((depth == 2'd0) || ((depth < DEPTH_MAX) && (win < top_id)));
    assign iret_pop = bus.i_iret && (depth != 2'd0);
    assign take_go  = (state == IDLE) && eligible && bus.i_int_en && bus.i_insn_ce && !bus.i_iret;
    assign clr      = (take_go ? (8'd1 << win) : 8'd0) | (pend_we ? bus.i_cfg_wdata[7:0] : 8'd0);

    always_comb begin
        state_n        = state;
        bus.o_irq_take = 1'b0;
        case (state)
            IDLE:   if (take_go) state_n = TAKE;
            TAKE: begin
                bus.o_irq_take = 1'b1;
                state_n        = SETTLE;
            end
            SETTLE: if (settle_cnt) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            settle_cnt <= 1'b0;
            sync1      <= 8'd0;
            sync2      <= 8'd0;
            sync3      <= 8'd0;
            mask_r     <= 8'd0;
            edge_en    <= 8'd0;
            pend_lat   <= 8'd0;
            depth      <= 2'd0;
            vec_r      <= VEC_BASE;
            for (int i = 0; i < N_DEPTH; i++) stk[i] <= 3'd0;
        end else begin
            state      <= state_n;
            settle_cnt <= (state == SETTLE) ? ~settle_cnt : 1'b0;
            sync1      <= bus.i_irq_req;
            sync2      <= sync1;
            sync3      <= sync2;
            // A new edge beats a same-cycle clear; an EDGE reconfiguration discards the latch
            pend_lat   <= (rise | (pend_lat & ~clr)) & ~edge_chg;
            if (mask_we) mask_r  <= bus.i_cfg_wdata[7:0];
            if (edge_we) edge_en <= bus.i_cfg_wdata[7:0];
            if (iret_pop) begin
                depth <= depth - 2'd1;
            end else if (take_go) begin
                stk[depth] <= win;
                depth      <= depth + 2'd1;
            end
            if (take_go) vec_r <= VEC_BASE + {11'd0, win, 2'b00};
        end
    end

    always_comb begin
        case (bus.i_cfg_addr)
            2'd0:    bus.o_cfg_rdata = {8'd0, mask_r};
            2'd1:    bus.o_cfg_rdata = {8'd0, pend};
            2'd2:    bus.o_cfg_rdata = {8'd0, edge_en};
            default: bus.o_cfg_rdata = {8'd0, depth, top_id, (depth != 2'd0), state};
        endcase
    end

    assign bus.o_irq_vector = vec_r;
    assign bus.o_depth      = depth;
endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - self-checking bench for irq_ctrl against a behavioural model
module tb_irq_ctrl;
    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    irq_ctrl_if bus();

    irq_ctrl #(.VEC_BASE(16'h0020), .N_DEPTH(3)) dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .bus    (bus.slave)
    );

    always #5 i_clk = ~i_clk;

    // Behavioural model: request history queue, id stack queue, busy countdown
    logic [7:0]  m_hist [$];
    logic [7:0]  m_mask, m_edge, m_pend;
    int          m_stack [$];
    int          m_busy;
    logic [15:0] m_vec;
    logic        m_take;

    task automatic model_reset();
        m_hist  = '{8'h00, 8'h00, 8'h00};
        m_mask  = 8'h00;
        m_edge  = 8'h00;
        m_pend  = 8'h00;
        m_stack = {};
        m_busy  = 0;
        m_vec   = 16'h0020;
        m_take  = 1'b0;
    endtask

    task automatic model_step();
        logic [7:0] s2, s3, pend, newp;
        int win, d;
        bit elig, go, set_b, clr_b;
        s2 = m_hist[1];
        s3 = m_hist[2];
        pend = (m_edge & m_pend) | (~m_edge & s2);
        win = -1;
        for (int i = 0; i < 8; i++) if (pend[i] && m_mask[i] && win < 0) win = i;
        d = m_stack.size();
        elig = (win >= 0) && (d == 0 || (d < 3 && win < m_stack[d-1]));
        go = (m_busy == 0) && elig && bus.i_int_en && bus.i_insn_ce && !bus.i_iret;
        m_take = go;
        if (bus.i_iret && d > 0) void'(m_stack.pop_back());
        if (go) begin
            m_stack.push_back(win);
            m_vec = 16'h0020 + 16'(win * 4);
        end
        if (m_busy > 0) m_busy--;
        if (go) m_busy = 3;
        newp = m_pend;
        for (int i = 0; i < 8; i++) begin
            set_b = m_edge[i] && s2[i] && !s3[i];
            clr_b = (go && win == i) ||
                    (bus.i_cfg_we && bus.i_cfg_addr == 2'd1 && bus.i_cfg_wdata[i]);
            if (set_b) newp[i] = 1'b1;
            else if (clr_b) newp[i] = 1'b0;
        end
        if (bus.i_cfg_we && bus.i_cfg_addr == 2'd2) begin
            newp   = newp & ~(bus.i_cfg_wdata[7:0] ^ m_edge);
            m_edge = bus.i_cfg_wdata[7:0];
        end
        if (bus.i_cfg_we && bus.i_cfg_addr == 2'd0) m_mask = bus.i_cfg_wdata[7:0];
        m_pend = newp;
        m_hist.push_front(bus.i_irq_req);
        void'(m_hist.pop_back());
    endtask

    function automatic logic [15:0] exp_rdata(logic [1:0] a);
        int d;
        logic [2:0] top;
        logic [1:0] st;
        d = m_stack.size();
        top = (d == 0) ? 3'd0 : 3'(m_stack[d-1]);
        st = (m_busy == 0) ? 2'd0 : (m_busy == 3) ? 2'd1 : 2'd2;
        case (a)
            2'd0:    return {8'd0, m_mask};
            2'd1:    return {8'd0, (m_edge & m_pend) | (~m_edge & m_hist[1])};
            2'd2:    return {8'd0, m_edge};
            default: return {8'd0, 2'(d), top, (d != 0), st};
        endcase
    endfunction

    task automatic tick();
        @(posedge i_clk);
        if (!i_rst_n) model_reset();
        else model_step();
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
        bus.i_cfg_we    = 1'b1;
        bus.i_cfg_addr  = a;
        bus.i_cfg_wdata = {8'd0, d};
        tick();
        bus.i_cfg_we    = 1'b0;
    endtask

    task automatic pulse_iret();
        bus.i_iret = 1'b1;
        tick();
        bus.i_iret = 1'b0;
    endtask

    task automatic wait_take(input int max_cycles, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            tick();
            if (bus.o_irq_take) seen = 1'b1;
        end
    endtask

    task automatic drain();
        bus.i_irq_req = 8'h00;
        cfg_write(2'd0, 8'h00);
        cfg_write(2'd2, 8'h00);
        cfg_write(2'd1, 8'hFF);
        for (int i = 0; i < 6; i++) tick();
        for (int i = 0; i < 4; i++) pulse_iret();
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.o_irq_take !== 1'b0 || bus.o_depth !== 2'd0 || bus.o_irq_vector !== 16'h0020) begin
            failures++;
            $display("FAIL reset_outputs: take=%b depth=%0d vec=%h required 0 0 0020",
                     bus.o_irq_take, bus.o_depth, bus.o_irq_vector);
        end
        for (int a = 0; a < 4; a++) begin
            bus.i_cfg_addr = 2'(a);
            #1;
            checks++;
            if (bus.o_cfg_rdata !== 16'h0000) begin
                failures++;
                $display("FAIL reset_reg%0d: got %h required 0000", a, bus.o_cfg_rdata);
            end
        end
        i_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_edge_take();
        int takes;
        logic [15:0] vec;
        cfg_write(2'd0, 8'h10);
        cfg_write(2'd2, 8'h10);
        bus.i_int_en = 1'b1;
        bus.i_insn_ce = 1'b1;
        bus.i_irq_req = 8'h10;
        tick();
        bus.i_irq_req = 8'h00;
        takes = 0;
        vec = 16'h0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.o_irq_take) begin
                takes++;
                vec = bus.o_irq_vector;
            end
        end
        checks++;
        if (takes != 1 || vec !== 16'h0030 || bus.o_depth !== 2'd1) begin
            failures++;
            $display("FAIL edge_take: takes=%0d vec=%h depth=%0d required 1 0030 1",
                     takes, vec, bus.o_depth);
        end
        bus.i_cfg_addr = 2'd1;
        #1;
        checks++;
        if (bus.o_cfg_rdata[4] !== 1'b0) begin
            failures++;
            $display("FAIL edge_pend_cleared: got %b required 0", bus.o_cfg_rdata[4]);
        end
        drain();
    endtask

    task automatic test_preempt();
        bit seen;
        int takes;
        bus.i_int_en = 1'b1;
        bus.i_insn_ce = 1'b1;
        cfg_write(2'd0, 8'h20);
        bus.i_irq_req = 8'h20;
        wait_take(20, seen);
        checks++;
        if (!seen || bus.o_irq_vector !== 16'h0034) begin
            failures++;
            $display("FAIL preempt_first: seen=%b vec=%h required 1 0034", seen, bus.o_irq_vector);
        end
        bus.i_irq_req = 8'h00;
        cfg_write(2'd0, 8'hFF);
        bus.i_irq_req = 8'h44;
        wait_take(20, seen);
        checks++;
        if (!seen || bus.o_irq_vector !== 16'h0028 || bus.o_depth !== 2'd2) begin
            failures++;
            $display("FAIL preempt_src2: seen=%b vec=%h depth=%0d required 1 0028 2",
                     seen, bus.o_irq_vector, bus.o_depth);
        end
        takes = 0;
        for (int i = 0; i < 8; i++) begin tick(); if (bus.o_irq_take) takes++; end
        bus.i_irq_req = 8'h40;
        for (int i = 0; i < 3; i++) begin tick(); if (bus.o_irq_take) takes++; end
        pulse_iret();
        for (int i = 0; i < 8; i++) begin tick(); if (bus.o_irq_take) takes++; end
        checks++;
        if (takes != 0 || bus.o_depth !== 2'd1) begin
            failures++;
            $display("FAIL preempt_src6_blocked: takes=%0d depth=%0d required 0 1", takes, bus.o_depth);
        end
        pulse_iret();
        if (bus.o_irq_take) seen = 1'b1; else wait_take(20, seen);
        checks++;
        if (!seen || bus.o_irq_vector !== 16'h0038 || bus.o_depth !== 2'd1) begin
            failures++;
            $display("FAIL preempt_src6_taken: seen=%b vec=%h depth=%0d required 1 0038 1",
                     seen, bus.o_irq_vector, bus.o_depth);
        end
        drain();
    endtask

    task automatic test_full_stack();
        bit seen, s0, s1, s2;
        int takes;
        bus.i_int_en = 1'b1;
        bus.i_insn_ce = 1'b1;
        cfg_write(2'd0, 8'hFF);
        bus.i_irq_req = 8'h40;
        wait_take(20, s0);
        bus.i_irq_req = 8'h10;
        wait_take(20, s1);
        bus.i_irq_req = 8'h02;
        wait_take(20, s2);
        bus.i_irq_req = 8'h00;
        checks++;
        if (!(s0 && s1 && s2) || bus.o_depth !== 2'd3) begin
            failures++;
            $display("FAIL full_fill: takes=%b%b%b depth=%0d required 111 3", s0, s1, s2, bus.o_depth);
        end
        cfg_write(2'd2, 8'h01);
        bus.i_irq_req = 8'h01;
        tick();
        bus.i_irq_req = 8'h00;
        takes = 0;
        for (int i = 0; i < 10; i++) begin tick(); if (bus.o_irq_take) takes++; end
        bus.i_cfg_addr = 2'd1;
        #1;
        checks++;
        if (takes != 0 || bus.o_cfg_rdata[0] !== 1'b1 || bus.o_depth !== 2'd3) begin
            failures++;
            $display("FAIL full_hold: takes=%0d pend0=%b depth=%0d required 0 1 3",
                     takes, bus.o_cfg_rdata[0], bus.o_depth);
        end
        pulse_iret();
        if (bus.o_irq_take) seen = 1'b1; else wait_take(20, seen);
        checks++;
        if (!seen || bus.o_irq_vector !== 16'h0020 || bus.o_depth !== 2'd3) begin
            failures++;
            $display("FAIL full_after_iret: seen=%b vec=%h depth=%0d required 1 0020 3",
                     seen, bus.o_irq_vector, bus.o_depth);
        end
        drain();
    endtask

    task automatic test_iret_collision();
        bit seen;
        bus.i_int_en = 1'b1;
        bus.i_insn_ce = 1'b1;
        cfg_write(2'd0, 8'h20);
        bus.i_irq_req = 8'h20;
        wait_take(20, seen);
        bus.i_irq_req = 8'h08;
        bus.i_int_en = 1'b0;
        cfg_write(2'd0, 8'h08);
        for (int i = 0; i < 6; i++) tick();
        bus.i_int_en = 1'b1;
        bus.i_iret = 1'b1;
        tick();
        bus.i_iret = 1'b0;
        checks++;
        if (!seen || bus.o_irq_take !== 1'b0 || bus.o_depth !== 2'd0) begin
            failures++;
            $display("FAIL collision_iret: setup=%b take=%b depth=%0d required 1 0 0",
                     seen, bus.o_irq_take, bus.o_depth);
        end
        tick();
        checks++;
        if (bus.o_irq_take !== 1'b1 || bus.o_irq_vector !== 16'h002C || bus.o_depth !== 2'd1) begin
            failures++;
            $display("FAIL collision_take: take=%b vec=%h depth=%0d required 1 002c 1",
                     bus.o_irq_take, bus.o_irq_vector, bus.o_depth);
        end
        drain();
    endtask

    task automatic test_reset_mid_take();
        bit seen;
        int takes;
        bus.i_int_en = 1'b1;
        bus.i_insn_ce = 1'b1;
        cfg_write(2'd0, 8'h08);
        bus.i_irq_req = 8'h08;
        wait_take(20, seen);
        i_rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (!seen || bus.o_irq_take !== 1'b0 || bus.o_depth !== 2'd0 || bus.o_irq_vector !== 16'h0020) begin
            failures++;
            $display("FAIL reset_mid_take: setup=%b take=%b depth=%0d vec=%h required 1 0 0 0020",
                     seen, bus.o_irq_take, bus.o_depth, bus.o_irq_vector);
        end
        tick();
        tick();
        i_rst_n = 1'b1;
        takes = 0;
        for (int i = 0; i < 8; i++) begin tick(); if (bus.o_irq_take) takes++; end
        checks++;
        if (takes != 0) begin
            failures++;
            $display("FAIL reset_no_spurious: takes=%0d required 0", takes);
        end
        drain();
    endtask

    task automatic test_w1c_race();
        bit seen;
        int takes;
        bus.i_int_en = 1'b0;
        bus.i_insn_ce = 1'b1;
        cfg_write(2'd0, 8'h08);
        cfg_write(2'd2, 8'h08);
        bus.i_irq_req = 8'h08;
        tick();
        bus.i_irq_req = 8'h00;
        tick();
        cfg_write(2'd1, 8'h08);
        bus.i_cfg_addr = 2'd1;
        #1;
        checks++;
        if (bus.o_cfg_rdata[3] !== 1'b1) begin
            failures++;
            $display("FAIL w1c_race_set_wins: pend3=%b required 1", bus.o_cfg_rdata[3]);
        end
        takes = 0;
        for (int i = 0; i < 6; i++) begin tick(); if (bus.o_irq_take) takes++; end
        checks++;
        if (takes != 0) begin
            failures++;
            $display("FAIL int_en_blocks: takes=%0d required 0", takes);
        end
        bus.i_int_en = 1'b1;
        wait_take(10, seen);
        checks++;
        if (!seen || bus.o_irq_vector !== 16'h002C) begin
            failures++;
            $display("FAIL int_en_take: seen=%b vec=%h required 1 002c", seen, bus.o_irq_vector);
        end
        drain();
    endtask

    task automatic test_random();
        logic [15:0] er;
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) bus.i_irq_req = 8'($urandom);
            bus.i_int_en  = ($urandom_range(0, 9) != 0);
            bus.i_insn_ce = ($urandom_range(0, 9) < 7);
            bus.i_iret    = ($urandom_range(0, 9) == 0);
            bus.i_cfg_we  = ($urandom_range(0, 7) == 0);
            bus.i_cfg_addr  = 2'($urandom);
            bus.i_cfg_wdata = 16'($urandom);
            tick();
            er = exp_rdata(bus.i_cfg_addr);
            checks++;
            if (bus.o_irq_take !== m_take || bus.o_irq_vector !== m_vec ||
                bus.o_depth !== 2'(m_stack.size()) || bus.o_cfg_rdata !== er) begin
                failures++;
                $display("FAIL random_c%0d: take=%b vec=%h depth=%0d rd[%0d]=%h required %b %h %0d %h",
                         c, bus.o_irq_take, bus.o_irq_vector, bus.o_depth, bus.i_cfg_addr,
                         bus.o_cfg_rdata, m_take, m_vec, m_stack.size(), er);
            end
        end
        bus.i_iret = 1'b0;
        bus.i_cfg_we = 1'b0;
    endtask

    initial begin
        bus.i_irq_req   = 8'h00;
        bus.i_int_en    = 1'b0;
        bus.i_insn_ce   = 1'b0;
        bus.i_iret      = 1'b0;
        bus.i_cfg_we    = 1'b0;
        bus.i_cfg_addr  = 2'd0;
        bus.i_cfg_wdata = 16'h0000;
        model_reset();
        test_reset();
        test_edge_take();
        test_preempt();
        test_full_stack();
        test_iret_collision();
        test_reset_mid_take();
        test_w1c_race();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
